nap_countdown: RTL and testbench

Consumer end of the nap-duration setting interface. Takes the BCD duration digits (one_sec, ten_sec, one_min) and the completeSetting flag produced by the keypad setting FSM. Counts the nap down once per second and exposes the remaining time for display. Raises an alarm at zero until the user stops it or the alarm timeout expires.

---
 rtl/nap_pkg.sv | 19 +
 rtl/sec_tick_gen.sv | 35 +++
 rtl/nap_countdown.sv | 153 +++++++++++++++
 tb/tb_nap_countdown.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nap_pkg.sv
// Shared definitions for the nap countdown: state encoding, BCD digit limits
// and the digit clamp applied when a requested duration is loaded.
package nap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam logic [3:0] SEC_UNIT_MAX = 4'd9;
    localparam logic [3:0] SEC_TEN_MAX  = 4'd5;
    localparam logic [3:0] MIN_MAX      = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: tick fires on the last enabled cycle of each second,
// then the count wraps. clear holds the count at zero.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              PW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_count;

    assign tick = enable & (r_count == LAST);

    // prescaler count, frozen while enable is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + PW'(1'b1);
            end
        end
    end

endmodule

// File: rtl/nap_countdown.sv
// Nap timer: loads a BCD duration on a setting-complete edge, counts it down
// once per second, then holds an alarm until stopped or timed out.
module nap_countdown
    import nap_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int ALARM_SEC     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       completeSetting,
    input  logic [3:0] one_sec,
    input  logic [3:0] ten_sec,
    input  logic [3:0] one_min,
    input  logic       stop,
    output logic [3:0] cnt_one_sec,
    output logic [3:0] cnt_ten_sec,
    output logic [3:0] cnt_one_min,
    output logic       running,
    output logic       alarm,
    output logic       done
);

    localparam int            AW         = $clog2(ALARM_SEC + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

    state_t        r_state;
    logic          r_cs_q;
    logic [3:0]    r_one, r_ten, r_min;
    logic [AW-1:0] r_alarm_cnt;
    logic          r_running, r_alarm, r_done;

    state_t        w_state_nxt;
    logic [3:0]    w_one_nxt, w_ten_nxt, w_min_nxt;
    logic [AW-1:0] w_alarm_cnt_nxt;
    logic          w_start, w_tick, w_pre_clr, w_pre_en, w_final, w_load_zero;
    logic [3:0]    w_ld_one, w_ld_ten, w_ld_min;

    assign w_start     = completeSetting & ~r_cs_q & en;
    assign w_ld_one    = bcd_clamp(one_sec, SEC_UNIT_MAX);
    assign w_ld_ten    = bcd_clamp(ten_sec, SEC_TEN_MAX);
    assign w_ld_min    = bcd_clamp(one_min, MIN_MAX);
    assign w_load_zero = (w_ld_one == 4'd0) && (w_ld_ten == 4'd0) && (w_ld_min == 4'd0);
    assign w_final     = (r_one == 4'd1) && (r_ten == 4'd0) && (r_min == 4'd0);

    sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_pre_clr),
        .enable (w_pre_en),
        .tick   (w_tick)
    );

    // next-state, BCD borrow countdown and alarm-second accounting
    always_comb begin
        w_state_nxt     = r_state;
        w_one_nxt       = r_one;
        w_ten_nxt       = r_ten;
        w_min_nxt       = r_min;
        w_alarm_cnt_nxt = r_alarm_cnt;
        w_pre_clr       = 1'b0;
        w_pre_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pre_clr       = 1'b1;
                w_alarm_cnt_nxt = '0;
                if (w_start) begin
                    w_one_nxt   = w_ld_one;
                    w_ten_nxt   = w_ld_ten;
                    w_min_nxt   = w_ld_min;
                    w_state_nxt = w_load_zero ? ST_ALARM : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_pre_en = en;
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_one_nxt   = 4'd0;
                    w_ten_nxt   = 4'd0;
                    w_min_nxt   = 4'd0;
                end else if (w_tick && w_final) begin
                    w_state_nxt = ST_ALARM;
                    w_one_nxt   = 4'd0;
                end else if (w_tick) begin
                    if (r_one != 4'd0) begin
                        w_one_nxt = r_one - 4'd1;
                    end else begin
                        w_one_nxt = SEC_UNIT_MAX;
                        if (r_ten != 4'd0) begin
                            w_ten_nxt = r_ten - 4'd1;
                        end else begin
                            w_ten_nxt = SEC_TEN_MAX;
                            w_min_nxt = r_min - 4'd1;
                        end
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ALARM: begin
                // alarm timing ignores en so a paused block still times out
                w_pre_en = 1'b1;
                if (stop || (w_tick && (r_alarm_cnt == ALARM_LAST))) begin
                    w_state_nxt     = ST_IDLE;
                    w_alarm_cnt_nxt = '0;
                end else if (w_tick) begin
                    w_alarm_cnt_nxt = r_alarm_cnt + AW'(1'b1);
                end else begin
                    w_state_nxt = ST_ALARM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // state, counters and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cs_q      <= 1'b0;
            r_one       <= 4'd0;
            r_ten       <= 4'd0;
            r_min       <= 4'd0;
            r_alarm_cnt <= '0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cs_q      <= completeSetting;
            r_one       <= w_one_nxt;
            r_ten       <= w_ten_nxt;
            r_min       <= w_min_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_running   <= (w_state_nxt == ST_RUN);
            r_alarm     <= (w_state_nxt == ST_ALARM);
            r_done      <= (w_state_nxt == ST_ALARM) && (r_state != ST_ALARM);
        end
    end

    assign cnt_one_sec = r_one;
    assign cnt_ten_sec = r_ten;
    assign cnt_one_min = r_min;
    assign running     = r_running;
    assign alarm       = r_alarm;
    assign done        = r_done;

endmodule

// File: tb/tb_nap_countdown.sv
// Self-checking bench for nap_countdown: directed scenarios plus random
// stimulus, compared every cycle against a seconds-based reference model.
module tb_nap_countdown;

    localparam int TPS  = 4;
    localparam int ASEC = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_ALARM = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       completeSetting = 1'b0;
    logic [3:0] one_sec = 4'd0, ten_sec = 4'd0, one_min = 4'd0;
    logic       stop = 1'b0;
    logic [3:0] cnt_one_sec, cnt_ten_sec, cnt_one_min;
    logic       running, alarm, done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: remaining time kept as plain seconds
    int m_mode = M_IDLE;
    int m_rem = 0;
    int m_phase = 0;
    int m_asec = 0;
    int m_done = 0;
    int m_prev_cs = 0;

    nap_countdown #(.TICKS_PER_SEC(TPS), .ALARM_SEC(ASEC)) dut (
        .clock           (clock),
        .reset           (reset),
        .en              (en),
        .completeSetting (completeSetting),
        .one_sec         (one_sec),
        .ten_sec         (ten_sec),
        .one_min         (one_min),
        .stop            (stop),
        .cnt_one_sec     (cnt_one_sec),
        .cnt_ten_sec     (cnt_ten_sec),
        .cnt_one_min     (cnt_one_min),
        .running         (running),
        .alarm           (alarm),
        .done            (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_rem = 0; m_phase = 0; m_asec = 0; m_done = 0; m_prev_cs = 0;
    endtask

    task automatic model_edge();
        int start;
        if (reset) begin
            model_reset();
            return;
        end
        start = (completeSetting && !m_prev_cs && en) ? 1 : 0;
        m_prev_cs = completeSetting ? 1 : 0;
        m_done = 0;
        case (m_mode)
            M_IDLE: if (start) begin
                m_rem = lim(int'(one_min), 9) * 60 + lim(int'(ten_sec), 5) * 10 + lim(int'(one_sec), 9);
                m_phase = 0;
                m_asec = 0;
                if (m_rem > 0) m_mode = M_RUN;
                else begin m_mode = M_ALARM; m_done = 1; end
            end
            M_RUN: begin
                if (stop) begin
                    m_mode = M_IDLE; m_rem = 0; m_phase = 0;
                end else if (en) begin
                    m_phase++;
                    if (m_phase == TPS) begin
                        m_phase = 0;
                        m_rem--;
                        if (m_rem == 0) begin m_mode = M_ALARM; m_done = 1; m_asec = 0; end
                    end
                end
            end
            default: begin
                if (stop) begin
                    m_mode = M_IDLE; m_phase = 0; m_asec = 0;
                end else begin
                    m_phase++;
                    if (m_phase == TPS) begin
                        m_phase = 0;
                        m_asec++;
                        if (m_asec == ASEC) begin m_mode = M_IDLE; m_asec = 0; end
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        int exp_cnt;
        exp_cnt = (m_rem / 60) * 256 + ((m_rem % 60) / 10) * 16 + (m_rem % 10);
        check_eq({tag, ".cnt"}, {20'd0, cnt_one_min, cnt_ten_sec, cnt_one_sec}, exp_cnt);
        check_eq({tag, ".running"}, {31'd0, running}, (m_mode == M_RUN) ? 1 : 0);
        check_eq({tag, ".alarm"}, {31'd0, alarm}, (m_mode == M_ALARM) ? 1 : 0);
        check_eq({tag, ".done"}, {31'd0, done}, m_done);
    endtask

    task automatic step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge();
            #1;
            compare_all(tag);
        end
    endtask

    task automatic nap_start(input string tag, input logic [3:0] mn, input logic [3:0] tn, input logic [3:0] on);
        one_min = mn; ten_sec = tn; one_sec = on;
        completeSetting = 1'b1;
        step(tag, 1);
        completeSetting = 1'b0;
    endtask

    initial begin
        step("reset", 2);
        reset = 1'b0;
        step("idle", 2);

        nap_start("n005", 4'd0, 4'd0, 4'd5);
        step("n005", 40);

        nap_start("n100", 4'd1, 4'd0, 4'd0);
        step("n100", 260);

        nap_start("n030", 4'd0, 4'd3, 4'd0);
        step("n030", 10);
        en = 1'b0;
        step("n030_pause", 20);
        en = 1'b1;
        step("n030_resume", 130);

        nap_start("n003", 4'd0, 4'd0, 4'd3);
        step("n003", 11);
        stop = 1'b1;
        step("n003_stop", 1);
        stop = 1'b0;
        step("n003_after", 8);

        nap_start("n001", 4'd0, 4'd0, 4'd1);
        step("alarm_to", 20);
        nap_start("n001b", 4'd0, 4'd0, 4'd1);
        step("n001b", 6);
        stop = 1'b1;
        step("alarm_stop", 1);
        stop = 1'b0;
        step("alarm_stop", 3);

        nap_start("clamp", 4'd0, 4'd7, 4'd12);
        step("clamp", 6);
        nap_start("restart_ign", 4'd0, 4'd0, 4'd2);
        step("restart_ign", 4);
        stop = 1'b1;
        step("clamp_stop", 1);
        stop = 1'b0;

        nap_start("zero", 4'd0, 4'd0, 4'd0);
        step("zero", 16);

        en = 1'b0;
        nap_start("en_low", 4'd0, 4'd0, 4'd4);
        completeSetting = 1'b1;
        step("en_low", 2);
        en = 1'b1;
        step("cs_held", 6);
        completeSetting = 1'b0;
        step("cs_held", 2);

        nap_start("rst_mid", 4'd0, 4'd2, 4'd0);
        step("rst_mid", 9);
        reset = 1'b1;
        #1;
        check_eq("async_rst.cnt", {20'd0, cnt_one_min, cnt_ten_sec, cnt_one_sec}, 32'd0);
        check_eq("async_rst.flags", {29'd0, running, alarm, done}, 32'd0);
        step("rst_hold", 2);
        reset = 1'b0;
        step("rst_after", 2);

        for (int c = 0; c < 2500; c++) begin
            en   = ($urandom_range(0, 9) != 0);
            stop = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if (!completeSetting) begin
                    one_sec = 4'($urandom_range(0, 15));
                    ten_sec = 4'($urandom_range(0, 15));
                    one_min = 4'($urandom_range(0, 1));
                end
                completeSetting = ~completeSetting;
            end
            step("rand", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
